sobel_edge_detect_8bit: RTL and testbench
=========================================

SOBEL_EDGE_DETECT_8BIT -- requirements
Module: sobel_edge_detect_8bit

Interface
REQ-001 SHALL have parameter SOBEL_THRESHOLD, default 8'd40: threshold loaded into the active-threshold register at reset.
REQ-002 SHALL have parameter CNT_WIDTH, default 20: width of the per-frame edge counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  pixel clock, all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 matrix_frame_vsync  input  1  upstream 3x3 window vsync, high = frame valid.
REQ-007 matrix_frame_href  input  1  upstream window href, high = window valid.
REQ-008 matrix_p11..matrix_p33  input  8 each  3x3 gray window: row 1 top, column 1 left.
REQ-009 threshold  input  8  requested edge threshold, sampled per frame.
REQ-010 post_frame_vsync  output  1  vsync delayed to align with the outputs.
REQ-011 post_frame_href  output  1  href delayed to align with the outputs.
REQ-012 post_img_Gray  output  8  gradient magnitude, saturated to 255.
REQ-013 post_img_Bit  output  1  1 = edge pixel.
REQ-014 frame_edge_cnt  output  CNT_WIDTH  edge-pixel count of the last completed frame.
REQ-015 frame_done  output  1  one-cycle pulse when frame_edge_cnt updates.

Function
REQ-016 Stage 1 (registered) SHALL compute four 10-bit unsigned sums:
- Gx_a = p13+2*p23+p33 and Gx_b = p11+2*p21+p31.
- Gy_a = p11+2*p12+p13 and Gy_b = p31+2*p32+p33.
REQ-017 Stage 2 (registered) SHALL compute Gx = |Gx_a-Gx_b| and Gy = |Gy_a-Gy_b| as 10-bit values, each at most 1020.
REQ-018 Stage 3 (registered) SHALL compute G = Gx+Gy as an 11-bit value; no square root is used.
REQ-019 Stage 4 (registered) SHALL drive post_img_Gray = (G>255) ? 255 : G[7:0] and post_img_Bit = (G >= active threshold), compared at 11-bit width.
REQ-020 Latency SHALL be exactly 4 clk from a window input to its outputs; post_frame_vsync and post_frame_href SHALL be their inputs delayed by a 4-deep shift register.
REQ-021 When post_frame_href=0, post_img_Gray SHALL be 0 and post_img_Bit SHALL be 0, regardless of pixel data.
REQ-022 The pipeline SHALL accept a new window every cycle with no stall and no backpressure.
REQ-023 The active threshold SHALL load from threshold only on the rising edge of matrix_frame_vsync (previous-cycle 0, current 1).
REQ-024 A threshold change within a frame SHALL take effect only for the next frame.
REQ-025 The edge counter SHALL increment when post_frame_href=1 and post_img_Bit=1, and SHALL saturate at all-ones without wrapping.
REQ-026 On the falling edge of post_frame_vsync, frame_edge_cnt SHALL load the counter value including the current cycle's increment, frame_done SHALL pulse high for 1 cycle, and the counter SHALL clear.
REQ-027 A vsync rising edge with no preceding falling edge (a truncated frame) SHALL not produce frame_done.
REQ-028 A post_frame_href pulse while post_frame_vsync=0 SHALL still update pixel outputs but SHALL not be counted.

Reset
REQ-029 While rst_n=0, all pipeline registers, delay lines, post_* outputs, the counter, frame_edge_cnt and frame_done SHALL be 0, and the active threshold SHALL equal SOBEL_THRESHOLD.
REQ-030 A reset asserted mid-frame SHALL discard the partial frame: no frame_done, counter 0, and the first post-reset vsync rise reloads the threshold.

Verification
REQ-031 All nine pixels =100 with href=1 -> post_img_Gray=0 and post_img_Bit=0 on cycle 4 after input.
REQ-032 Vertical step (p11,p21,p31=0; p13,p23,p33=255; p12=p22=p32=128) -> G=1020, post_img_Gray=255, post_img_Bit=1, exactly 4 cycles later.
REQ-033 Horizontal step (top row 0, bottom row 60, middle row 30) with threshold=240 -> G=240 and Bit=1; with threshold=241 -> Bit=0.
REQ-034 A 16x4 frame of REQ-032 windows -> frame_edge_cnt=64 and a single frame_done pulse one cycle after post_frame_vsync falls.
REQ-035 Change threshold from 40 to 250 mid-frame -> current frame still uses 40; next frame uses 250.
REQ-036 Assert rst_n=0 for 2 cycles mid-frame -> all outputs 0, no frame_done; the following full 16x4 frame reports 64.

Source files
------------

// File: rtl/sobel_edge_detect_8bit.sv
// Sobel edge detector over a 3x3 gray window.
// Four-stage pipeline with a per-frame edge counter.
module sobel_edge_detect_8bit #(
  parameter logic [7:0] SOBEL_THRESHOLD = 8'd40,
  parameter int         CNT_WIDTH       = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 matrix_frame_vsync,
  input  logic                 matrix_frame_href,
  input  logic [7:0]           matrix_p11,
  input  logic [7:0]           matrix_p12,
  input  logic [7:0]           matrix_p13,
  input  logic [7:0]           matrix_p21,
  input  logic [7:0]           matrix_p22,
  input  logic [7:0]           matrix_p23,
  input  logic [7:0]           matrix_p31,
  input  logic [7:0]           matrix_p32,
  input  logic [7:0]           matrix_p33,
  input  logic [7:0]           threshold,
  output logic                 post_frame_vsync,
  output logic                 post_frame_href,
  output logic [7:0]           post_img_Gray,
  output logic                 post_img_Bit,
  output logic [CNT_WIDTH-1:0] frame_edge_cnt,
  output logic                 frame_done
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [9:0]           gxa_q, gxa_d;
  logic [9:0]           gxb_q, gxb_d;
  logic [9:0]           gya_q, gya_d;
  logic [9:0]           gyb_q, gyb_d;
  logic [9:0]           gx_q, gx_d;
  logic [9:0]           gy_q, gy_d;
  logic [10:0]          g_q, g_d;
  logic [7:0]           gray_q, gray_d;
  logic                 bit_q, bit_d;
  logic [3:0]           vs_sr_q, vs_sr_d;
  logic [3:0]           hs_sr_q, hs_sr_d;
  logic [3:0]           ok_sr_q, ok_sr_d;
  logic                 seen_low_q, seen_low_d;
  logic                 vs_prev_q, vs_prev_d;
  logic [7:0]           thr_q, thr_d;
  logic                 frm_prev_q, frm_prev_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                 done_q, done_d;

  function automatic logic [9:0] wsum(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Stage 1: weighted column and row sums
  always_comb begin
    gxa_d = wsum(matrix_p13, matrix_p23, matrix_p33);
    gxb_d = wsum(matrix_p11, matrix_p21, matrix_p31);
    gya_d = wsum(matrix_p11, matrix_p12, matrix_p13);
    gyb_d = wsum(matrix_p31, matrix_p32, matrix_p33);
  end

  // Stage 2: absolute differences
  always_comb begin
    gx_d = (gxa_q >= gxb_q) ? gxa_q - gxb_q : gxb_q - gxa_q;
    gy_d = (gya_q >= gyb_q) ? gya_q - gyb_q : gyb_q - gya_q;
  end

  // Stage 3: L1 magnitude
  always_comb begin
    g_d = {1'b0, gx_q} + {1'b0, gy_q};
  end

  // Stage 4: saturate, threshold, blank outside href
  always_comb begin
    gray_d = 8'd0;
    bit_d  = 1'b0;
    if (hs_sr_q[2]) begin
      gray_d = (g_q > 11'd255) ? 8'hFF : g_q[7:0];
      bit_d  = (g_q >= {3'b000, thr_q});
    end
  end

  // Sync delay lines; ok marks vsync of a frame whose start was seen
  always_comb begin
    vs_sr_d    = {vs_sr_q[2:0], matrix_frame_vsync};
    hs_sr_d    = {hs_sr_q[2:0], matrix_frame_href};
    ok_sr_d    = {ok_sr_q[2:0], matrix_frame_vsync & seen_low_q};
    seen_low_d = seen_low_q | ~matrix_frame_vsync;
  end

  // Active threshold reloads on the input vsync rising edge
  always_comb begin
    vs_prev_d = matrix_frame_vsync;
    thr_d     = thr_q;
    if (matrix_frame_vsync && !vs_prev_q) thr_d = threshold;
  end

  // Edge counter with frame-end capture
  always_comb begin
    logic inc;
    logic fall;
    logic [CNT_WIDTH-1:0] nxt;
    inc  = ok_sr_q[3] & hs_sr_q[3] & bit_q;
    fall = frm_prev_q & ~ok_sr_q[3];
    nxt  = (inc && cnt_q != CNT_MAX) ? cnt_q + CNT_ONE : cnt_q;
    frm_prev_d = ok_sr_q[3];
    cnt_d      = nxt;
    edge_cnt_d = edge_cnt_q;
    done_d     = 1'b0;
    if (fall) begin
      cnt_d      = '0;
      edge_cnt_d = nxt;
      done_d     = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gxa_q      <= '0;
      gxb_q      <= '0;
      gya_q      <= '0;
      gyb_q      <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      g_q        <= '0;
      gray_q     <= '0;
      bit_q      <= 1'b0;
      vs_sr_q    <= '0;
      hs_sr_q    <= '0;
      ok_sr_q    <= '0;
      seen_low_q <= 1'b0;
      vs_prev_q  <= 1'b0;
      thr_q      <= SOBEL_THRESHOLD;
      frm_prev_q <= 1'b0;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      gxa_q      <= gxa_d;
      gxb_q      <= gxb_d;
      gya_q      <= gya_d;
      gyb_q      <= gyb_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      g_q        <= g_d;
      gray_q     <= gray_d;
      bit_q      <= bit_d;
      vs_sr_q    <= vs_sr_d;
      hs_sr_q    <= hs_sr_d;
      ok_sr_q    <= ok_sr_d;
      seen_low_q <= seen_low_d;
      vs_prev_q  <= vs_prev_d;
      thr_q      <= thr_d;
      frm_prev_q <= frm_prev_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      done_q     <= done_d;
    end
  end

  assign post_frame_vsync = vs_sr_q[3];
  assign post_frame_href  = hs_sr_q[3];
  assign post_img_Gray    = gray_q;
  assign post_img_Bit     = bit_q;
  assign frame_edge_cnt   = edge_cnt_q;
  assign frame_done       = done_q;

endmodule

// File: tb/tb_sobel_edge_detect_8bit.sv
// Random and directed bench for the Sobel edge detector.
// Reference model works on whole windows and frames.
module tb_sobel_edge_detect_8bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs_in, hs_in;
  logic [7:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [7:0]  thr_in;
  logic        post_vs, post_hs;
  logic [7:0]  post_gray;
  logic        post_bit;
  logic [19:0] edge_cnt;
  logic        done;

  sobel_edge_detect_8bit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .matrix_frame_vsync (vs_in),
    .matrix_frame_href  (hs_in),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (p22),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33),
    .threshold          (thr_in),
    .post_frame_vsync   (post_vs),
    .post_frame_href    (post_hs),
    .post_img_Gray      (post_gray),
    .post_img_Bit       (post_bit),
    .frame_edge_cnt     (edge_cnt),
    .frame_done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            vs;
    logic            hs;
    logic [8:0][7:0] p;
    logic [7:0]      thr;
  } rec_t;

  rec_t        hist[$];
  int          checks = 0;
  int          fails  = 0;
  int          thr_m;
  bit          prev_vs_m;
  int          frame_acc;
  int          cyc = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  int          fall_cyc = 0;
  logic [19:0] done_val = '0;
  bit          prev_post_vs;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_g(rec_t r);
    int q[9];
    for (int i = 0; i < 9; i++) q[i] = int'(r.p[i]);
    return iabs((q[2] + 2*q[5] + q[8]) - (q[0] + 2*q[3] + q[6]))
         + iabs((q[0] + 2*q[1] + q[2]) - (q[6] + 2*q[7] + q[8]));
  endfunction

  function automatic rec_t mk(int kind, int rng);
    rec_t r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      case (kind)
        0: r.p[i] = (i % 3 == 0) ? 8'd0 : (i % 3 == 2) ? 8'd255 : 8'd128;
        2: r.p[i] = 8'd100;
        3: r.p[i] = (i < 3) ? 8'd0 : (i < 6) ? 8'd30 : 8'd60;
        default: r.p[i] = 8'($urandom_range(0, rng));
      endcase
    end
    return r;
  endfunction

  task automatic check_zero(string tag);
    chk({tag, "_vs"}, 32'(post_vs), 0);
    chk({tag, "_hs"}, 32'(post_hs), 0);
    chk({tag, "_gray"}, 32'(post_gray), 0);
    chk({tag, "_bit"}, 32'(post_bit), 0);
    chk({tag, "_cnt"}, 32'(edge_cnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic step(bit vs, bit hs, rec_t r, int thr);
    rec_t e;
    int   g;
    vs_in  = vs;
    hs_in  = hs;
    thr_in = 8'(thr);
    p11 = r.p[0]; p12 = r.p[1]; p13 = r.p[2];
    p21 = r.p[3]; p22 = r.p[4]; p23 = r.p[5];
    p31 = r.p[6]; p32 = r.p[7]; p33 = r.p[8];
    if (vs && !prev_vs_m) thr_m = thr;
    prev_vs_m = vs;
    r.vs  = vs;
    r.hs  = hs;
    r.thr = 8'(thr_m);
    if (vs && hs && ref_g(r) >= thr_m) frame_acc++;
    hist.push_back(r);
    if (hist.size() > 4) void'(hist.pop_front());
    @(posedge clk);
    #1;
    cyc++;
    if (hist.size() == 4) begin
      e = hist[0];
      g = ref_g(e);
      chk("post_vs", 32'(post_vs), 32'(e.vs));
      chk("post_hs", 32'(post_hs), 32'(e.hs));
      chk("gray", 32'(post_gray), e.hs ? ((g > 255) ? 255 : g) : 0);
      chk("bit", 32'(post_bit), (e.hs && g >= int'(e.thr)) ? 1 : 0);
    end else begin
      chk("fill_hs", 32'(post_hs), 0);
      chk("fill_gray", 32'(post_gray), 0);
      chk("fill_bit", 32'(post_bit), 0);
    end
    if (!post_vs && prev_post_vs) fall_cyc = cyc;
    prev_post_vs = post_vs;
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_val = edge_cnt;
    end
  endtask

  task automatic frame(int kind, int lines, int width,
                       int thr0, int thr1, int chg_at, int rng);
    int n;
    int d0;
    int t;
    bit hs;
    n  = 0;
    d0 = done_n;
    t  = thr0;
    frame_acc = 0;
    for (int i = 0; i < 3; i++) step(0, 0, mk(2, 0), thr0);
    for (int i = 0; i < 2; i++) step(1, 0, mk(1, 255), thr0);
    for (int l = 0; l < lines; l++) begin
      for (int w = 0; w < width; w++) begin
        t  = (n >= chg_at) ? thr1 : thr0;
        hs = (kind == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
        step(1, hs, mk(kind, rng), t);
        n++;
      end
      for (int i = 0; i < 3; i++) step(1, 0, mk(1, 255), t);
    end
    for (int i = 0; i < 8; i++) begin
      hs = (kind == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      step(0, hs, mk(1, 255), t);
    end
    chk("fr_pulses", done_n - d0, 1);
    chk("fr_cnt", 32'(done_val), frame_acc);
    chk("fr_lat", done_cyc - fall_cyc, 1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_zero("rst_hold");
    end
    hist.delete();
    thr_m        = 40;
    prev_vs_m    = 1'b0;
    prev_post_vs = 1'b0;
    rst_n        = 1'b1;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    vs_in = 1'b0;
    hs_in = 1'b0;
    thr_in = 8'd0;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = '0;
    thr_m = 40;
    prev_vs_m = 1'b0;
    prev_post_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    frame(2, 1, 4, 40, 40, 0, 0);
    chk("flat_cnt", 32'(done_val), 0);

    frame(0, 4, 16, 40, 40, 0, 0);
    chk("vstep_cnt64", 32'(done_val), 64);

    frame(3, 1, 4, 240, 240, 0, 0);
    chk("hstep_240", 32'(done_val), 4);
    frame(3, 1, 4, 241, 241, 0, 0);
    chk("hstep_241", 32'(done_val), 0);

    frame(3, 2, 8, 40, 250, 8, 0);
    chk("thr_keep", 32'(done_val), 16);
    frame(3, 1, 8, 250, 250, 0, 0);
    chk("thr_next", 32'(done_val), 0);

    frame(1, 4, 16, 40, 250, 30, 120);
    frame(1, 4, 16, 250, 250, 0, 255);

    for (int k = 0; k < 6; k++)
      frame(1, 3, 12, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 36), $urandom_range(20, 255));

    d0 = done_n;
    for (int i = 0; i < 3; i++) step(0, 0, mk(2, 0), 40);
    step(1, 0, mk(2, 0), 40);
    for (int i = 0; i < 10; i++) step(1, 1, mk(0, 0), 40);
    reset_pulse();
    for (int i = 0; i < 10; i++) step(1, 1, mk(0, 0), 40);
    for (int i = 0; i < 10; i++) step(0, 0, mk(2, 0), 40);
    chk("rst_no_done", done_n - d0, 0);
    chk("rst_cnt_zero", 32'(edge_cnt), 0);

    frame(0, 4, 16, 40, 40, 0, 0);
    chk("post_rst_cnt64", 32'(done_val), 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
